// File: rtl/sram_controller.sv
// Bridges 32-bit pipeline loads/stores onto a 16-bit asynchronous SRAM as two
// halfword accesses, freezing the pipeline (ready=0) until the access completes.
module sram_controller #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_res,
  input  logic [31:0] ST_val,
  output logic [31:0] mem_out,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [16:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] mem_out_q, mem_out_d;
  logic [31:0] eff;
  logic        last_cycle;
  logic        unused_eff;

  // SRAM window starts at byte address 1024; the byte offset within a word is dropped.
  assign eff        = ALU_res - 32'd1024;
  assign unused_eff = ^{eff[31:19], eff[1:0]};
  assign last_cycle = (cnt_q == LAST_CNT);
  assign mem_out    = mem_out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 17'd0;
      data_q    <= 32'd0;
      mem_out_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      mem_out_q <= mem_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    mem_out_d = mem_out_q;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (MEM_W_EN) begin
          state_d = WR_LO;
          addr_d  = eff[18:2];
          data_d  = ST_val;
        end else if (MEM_R_EN) begin
          state_d = RD_LO;
          addr_d  = eff[18:2];
        end
      end
      RD_LO, RD_HI, WR_LO, WR_HI: begin
        if (last_cycle) begin
          cnt_d = 4'd0;
          case (state_q)
            RD_LO: begin
              state_d         = RD_HI;
              mem_out_d[15:0] = sram_dq_in;
            end
            RD_HI: begin
              state_d          = DONE;
              mem_out_d[31:16] = sram_dq_in;
            end
            WR_LO:   state_d = WR_HI;
            default: state_d = DONE;
          endcase
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      // DONE always returns to IDLE so a request still held high is not re-issued.
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready       = 1'b0;
    sram_addr   = 18'd0;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state_q)
      IDLE:  ready = ~(MEM_W_EN | MEM_R_EN);
      DONE:  ready = 1'b1;
      RD_LO: sram_addr = {addr_q, 1'b0};
      RD_HI: sram_addr = {addr_q, 1'b1};
      WR_LO: begin
        sram_addr   = {addr_q, 1'b0};
        sram_dq_out = data_q[15:0];
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
      end
      WR_HI: begin
        sram_addr   = {addr_q, 1'b1};
        sram_dq_out = data_q[31:16];
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
      end
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed self-checking bench for sram_controller with a small behavioural SRAM.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_res;
  logic [31:0] ST_val;
  logic [31:0] mem_out;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  logic [15:0] sram_mem [0:15];

  int errors = 0;
  int checks = 0;

  sram_controller #(.WAIT_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_R_EN   (MEM_R_EN),
    .MEM_W_EN   (MEM_W_EN),
    .ALU_res    (ALU_res),
    .ST_val     (ST_val),
    .mem_out    (mem_out),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM: combinational read, write committed at the end of each strobed cycle.
  assign sram_dq_in = sram_mem[sram_addr[3:0]];
  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr[3:0]] <= sram_dq_out;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    MEM_W_EN = w;
    MEM_R_EN = r;
    ALU_res  = a;
    ST_val   = d;
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic checkWriteCycle(input string tag, input logic [17:0] a, input logic [15:0] d);
    checkOutput({tag, " we_n"}, {31'd0, sram_we_n}, 32'd0);
    checkOutput({tag, " oe"}, {31'd0, sram_dq_oe}, 32'd1);
    checkOutput({tag, " addr"}, {14'd0, sram_addr}, {14'd0, a});
    checkOutput({tag, " dq_out"}, {16'd0, sram_dq_out}, {16'd0, d});
    checkOutput({tag, " ready"}, {31'd0, ready}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);

    // Reset state before any clock edge
    #2;
    checkOutput("rst mem_out", mem_out, 32'd0);
    checkOutput("rst addr", {14'd0, sram_addr}, 32'd0);
    checkOutput("rst dq_out", {16'd0, sram_dq_out}, 32'd0);
    checkOutput("rst oe", {31'd0, sram_dq_oe}, 32'd0);
    checkOutput("rst we_n", {31'd0, sram_we_n}, 32'd1);
    checkOutput("rst ready", {31'd0, ready}, 32'd1);
    waitCycle();
    waitCycle();
    rst = 1'b0;
    waitCycle();

    // Write 0xDEADBEEF at 0x400
    applyStimulus(1'b1, 1'b0, 32'h400, 32'hDEADBEEF);
    #1;
    checkOutput("wr c0 ready", {31'd0, ready}, 32'd0);
    checkOutput("wr c0 we_n", {31'd0, sram_we_n}, 32'd1);
    waitCycle(); checkWriteCycle("wr c1", 18'd0, 16'hBEEF);
    waitCycle(); checkWriteCycle("wr c2", 18'd0, 16'hBEEF);
    waitCycle(); checkWriteCycle("wr c3", 18'd1, 16'hDEAD);
    waitCycle(); checkWriteCycle("wr c4", 18'd1, 16'hDEAD);
    waitCycle();
    checkOutput("wr c5 ready", {31'd0, ready}, 32'd1);
    checkOutput("wr c5 we_n", {31'd0, sram_we_n}, 32'd1);
    checkOutput("wr c5 addr", {14'd0, sram_addr}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    waitCycle();
    checkOutput("wr idle ready", {31'd0, ready}, 32'd1);
    checkOutput("wr sram lo", {16'd0, sram_mem[0]}, 32'h0000BEEF);
    checkOutput("wr sram hi", {16'd0, sram_mem[1]}, 32'h0000DEAD);
    checkOutput("wr mem_out kept", mem_out, 32'd0);

    // Read back from 0x400
    applyStimulus(1'b0, 1'b1, 32'h400, 32'h0);
    #1;
    checkOutput("rd c0 ready", {31'd0, ready}, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      waitCycle();
      checkOutput("rd we_n", {31'd0, sram_we_n}, 32'd1);
      checkOutput("rd oe", {31'd0, sram_dq_oe}, 32'd0);
      checkOutput("rd ready", {31'd0, ready}, 32'd0);
      checkOutput("rd addr", {14'd0, sram_addr}, (c <= 2) ? 32'd0 : 32'd1);
    end
    waitCycle();
    checkOutput("rd c5 ready", {31'd0, ready}, 32'd1);
    checkOutput("rd c5 mem_out", mem_out, 32'hDEADBEEF);
    checkOutput("rd c5 we_n", {31'd0, sram_we_n}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    waitCycle();

    // Address map: 0x40C maps to halfwords 6 and 7
    applyStimulus(1'b1, 1'b0, 32'h40C, 32'h12345678);
    waitCycle(); checkWriteCycle("map c1", 18'd6, 16'h5678);
    waitCycle();
    waitCycle(); checkWriteCycle("map c3", 18'd7, 16'h1234);
    waitCycle();
    waitCycle();
    checkOutput("map c5 ready", {31'd0, ready}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    waitCycle();
    checkOutput("map sram 6", {16'd0, sram_mem[6]}, 32'h00005678);
    checkOutput("map sram 7", {16'd0, sram_mem[7]}, 32'h00001234);

    // Simultaneous read+write is a write; mem_out untouched
    applyStimulus(1'b1, 1'b1, 32'h410, 32'hCAFEF00D);
    #1;
    checkOutput("both c0 ready", {31'd0, ready}, 32'd0);
    waitCycle(); checkWriteCycle("both c1", 18'd8, 16'hF00D);
    waitCycle();
    waitCycle(); checkWriteCycle("both c3", 18'd9, 16'hCAFE);
    waitCycle();
    waitCycle();
    checkOutput("both c5 ready", {31'd0, ready}, 32'd1);
    checkOutput("both mem_out", mem_out, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    waitCycle();
    checkOutput("both sram 8", {16'd0, sram_mem[8]}, 32'h0000F00D);

    // Reset pulsed mid-cycle during WR_HI aborts the access at once
    applyStimulus(1'b1, 1'b0, 32'h414, 32'h11112222);
    waitCycle();
    waitCycle();
    waitCycle(); checkWriteCycle("abort c3", 18'd11, 16'h1111);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    #1;
    checkOutput("abort we_n", {31'd0, sram_we_n}, 32'd1);
    checkOutput("abort oe", {31'd0, sram_dq_oe}, 32'd0);
    checkOutput("abort addr", {14'd0, sram_addr}, 32'd0);
    checkOutput("abort dq_out", {16'd0, sram_dq_out}, 32'd0);
    checkOutput("abort mem_out", mem_out, 32'd0);
    checkOutput("abort ready", {31'd0, ready}, 32'd1);
    waitCycle();
    rst = 1'b0;
    waitCycle();
    checkOutput("abort idle we_n", {31'd0, sram_we_n}, 32'd1);
    checkOutput("abort sram 10", {16'd0, sram_mem[10]}, 32'h00002222);

    // Back-to-back reads with the request held through DONE
    applyStimulus(1'b0, 1'b1, 32'h40C, 32'h0);
    #1;
    checkOutput("b2b c0 ready", {31'd0, ready}, 32'd0);
    waitCycle(); checkOutput("b2b c1 addr", {14'd0, sram_addr}, 32'd6);
    waitCycle();
    waitCycle(); checkOutput("b2b c3 addr", {14'd0, sram_addr}, 32'd7);
    waitCycle();
    waitCycle();
    checkOutput("b2b c5 ready", {31'd0, ready}, 32'd1);
    checkOutput("b2b c5 mem_out", mem_out, 32'h12345678);
    applyStimulus(1'b0, 1'b1, 32'h400, 32'h0);
    waitCycle();
    checkOutput("b2b c6 idle addr", {14'd0, sram_addr}, 32'd0);
    checkOutput("b2b c6 ready", {31'd0, ready}, 32'd0);
    waitCycle(); checkOutput("b2b c7 addr", {14'd0, sram_addr}, 32'd0);
    checkOutput("b2b c7 ready", {31'd0, ready}, 32'd0);
    waitCycle();
    waitCycle(); checkOutput("b2b c9 addr", {14'd0, sram_addr}, 32'd1);
    waitCycle();
    waitCycle();
    checkOutput("b2b c11 ready", {31'd0, ready}, 32'd1);
    checkOutput("b2b c11 mem_out", mem_out, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    waitCycle();
    checkOutput("b2b c12 ready", {31'd0, ready}, 32'd1);
    checkOutput("b2b c12 addr", {14'd0, sram_addr}, 32'd0);
    checkOutput("b2b c12 mem_out", mem_out, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, giving the SRAM cycles held per 16-bit half access (legal range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port MEM_R_EN  input  1  load request from the memory pipeline stage.
REQ-005 SHALL have port MEM_W_EN  input  1  store request from the memory pipeline stage.
REQ-006 SHALL have port ALU_res  input  32  byte address of the request.
REQ-007 SHALL have port ST_val  input  32  store data.
REQ-008 SHALL have port mem_out  output  32  load data, registered.
REQ-009 SHALL have port ready  output  1  combinational; 0 tells the pipeline to freeze.
REQ-010 SHALL have port sram_addr  output  18  SRAM halfword address.
REQ-011 SHALL have port sram_dq_out  output  16  SRAM write data.
REQ-012 SHALL have port sram_dq_in  input  16  SRAM read data.
REQ-013 SHALL have port sram_dq_oe  output  1  1 = controller drives the SRAM data bus.
REQ-014 SHALL have port sram_we_n  output  1  SRAM write strobe, active low.

Function
REQ-015 SHALL implement states IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
REQ-016 Effective address SHALL be ALU_res - 32'd1024, modulo 2^32.
REQ-017 sram_addr SHALL be {eff[18:2], h}, where h = 0 in *_LO states and h = 1 in *_HI states; eff[1:0] is ignored.
REQ-018 In IDLE: MEM_W_EN=1 -> WR_LO; else MEM_R_EN=1 -> RD_LO; else stay in IDLE.
REQ-019 If MEM_W_EN and MEM_R_EN are both 1 in IDLE, the request SHALL be treated as a write.
REQ-020 A 4-bit wait counter SHALL clear on entry to each *_LO/*_HI state; the state SHALL be held exactly WAIT_CYCLES cycles.
REQ-021 State advance SHALL be LO -> HI -> DONE; DONE -> IDLE unconditionally after one cycle, so a still-asserted request is not re-issued.
REQ-022 ready SHALL be 1 in IDLE with no request and in DONE; 0 in IDLE with a request and in all *_LO/*_HI states.
REQ-023 Request latency SHALL be: request first seen in IDLE at cycle 0, ready=1 at cycle 2*WAIT_CYCLES+1 (cycle 5 at the default).
REQ-024 ALU_res and ST_val SHALL be sampled only in IDLE and held internally for the whole access.
REQ-025 In WR_LO/WR_HI, sram_we_n SHALL be 0, sram_dq_oe 1, and sram_dq_out ST_val[15:0] in WR_LO or ST_val[31:16] in WR_HI.
REQ-026 In all other states, sram_we_n SHALL be 1, sram_dq_oe 0, and sram_dq_out 0.
REQ-027 On the last cycle of RD_LO, sram_dq_in SHALL be captured into mem_out[15:0]; on the last cycle of RD_HI, into mem_out[31:16].
REQ-028 mem_out SHALL be valid in DONE and hold its value until the next read; writes SHALL not alter it.
REQ-029 sram_addr SHALL be 0 in IDLE and DONE.

Reset
REQ-030 While rst=1: state=IDLE, counter=0, mem_out=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
REQ-031 While rst=1, ready SHALL follow REQ-022 for IDLE.
REQ-032 Reset asserted mid-access SHALL abort the access immediately (asynchronously), with no further SRAM strobes; a partially written word is acceptable.

Verification
REQ-033 Reset: assert rst mid-cycle -> all outputs at REQ-030 values without waiting for a clk edge; ready=1 with no request.
REQ-034 Write: MEM_W_EN=1, ALU_res=0x400, ST_val=0xDEADBEEF held until ready.
  -> sram_we_n=0 for 2 cycles at sram_addr 0 with sram_dq_out=0xBEEF.
  -> then 2 cycles at sram_addr 1 with sram_dq_out=0xDEAD.
  -> ready=0 for cycles 0-4 and 1 at cycle 5.
REQ-035 Read: SRAM model holds BEEF@0 and DEAD@1; MEM_R_EN=1, ALU_res=0x400 -> mem_out=0xDEADBEEF at cycle 5; sram_we_n stays 1 throughout.
REQ-036 Address map: ALU_res=0x40C, write -> sram_addr sequence 6 then 7.
REQ-037 Simultaneous requests: MEM_R_EN=MEM_W_EN=1 -> write sequence performed (WR states), and mem_out is unchanged.
REQ-038 Abort and back-to-back:
  -> rst pulsed during WR_HI -> IDLE, sram_we_n=1.
  -> two consecutive reads, request kept asserted through DONE -> exactly one access per request, with IDLE between them.
